mem_access_ctrl: RTL and testbench
==================================

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 Port Clk  input  1  shall be the single clock; all state changes on rising edge.
REQ-002 Port Rst_n  input  1  shall be the asynchronous, active-low reset.
REQ-003 Port MemReadIn  input  1  shall be the load request from EX/MEM.
REQ-004 Port MemWriteIn  input  1  shall be the store request from EX/MEM.
REQ-005 Port bytes2LoadIn / bytes2StoreIn  input  2 each  shall be the access size: 00 word, 01 half, 10 byte, 11 reserved (treated as word).
REQ-006 Port LoadUnsignedIn  input  1  shall select zero-extension (1) or sign-extension (0) for half/byte loads.
REQ-007 Port ALUResultIn  input  32  shall be the byte address.
REQ-008 Port MemWriteDataIn  input  32  shall be the store data, right-justified.
REQ-009 Port MemReq / MemWe  output  1 each  shall be the memory request and write-enable.
REQ-010 Port MemAddr  output  32  shall be the word address ({addr[31:2],2'b00}).
REQ-011 Port MemByteEn  output  4  shall be the byte-lane enables; MemWData  output  32  shall be the lane-aligned store data.
REQ-012 Port MemAck  input  1  shall be the memory completion; MemRData  input  32  shall be valid while MemAck=1.
REQ-013 Port StallOut  output  1  shall freeze the upstream pipeline while high.
REQ-014 Port LoadDataOut  output  32 and LoadValidOut  output  1  shall carry the extended load result to MEM/WB.
REQ-015 Port MisalignOut / BusErrOut  output  1 each  shall be one-cycle error pulses.

Function
REQ-016 States shall be IDLE, REQ, DONE.
REQ-017 IDLE: access = MemReadIn|MemWriteIn; if both are high, the access shall be a store only.
REQ-018 Misaligned = half with addr[0]=1, or word with addr[1:0]!=0; a misaligned access shall issue no memory request and shall go to DONE with MisalignOut=1 in DONE.
REQ-019 An aligned access in IDLE shall capture address, data, size, signedness and direction, and shall go to REQ next edge.
REQ-020 REQ: MemReq=1 with all captured outputs stable until MemAck=1; then DONE next edge.
REQ-021 StallOut shall be high in IDLE while an access is present, and in REQ; it shall be low in DONE.
REQ-022 DONE shall last exactly one cycle, shall ignore inputs, and shall return to IDLE.
REQ-023 Byte store at lane k=addr[1:0] shall set MemByteEn bit k and replicate data[7:0] into all lanes; half store shall use 0011 (addr[1]=0) or 1100, with data[15:0] replicated; word store shall use 1111.
REQ-024 Loads shall use the same MemByteEn; the selected lane(s) of MemRData shall be right-justified and sign- or zero-extended, and registered into LoadDataOut on the MemAck edge.
REQ-025 LoadValidOut shall be 1 only in DONE after a completed load; LoadDataOut shall hold its value until the next load completes.
REQ-026 A 4-bit timeout counter shall clear on entry to REQ; if 16 REQ cycles pass without MemAck, the block shall drop MemReq, go to DONE, pulse BusErrOut, and load 0 into LoadDataOut.
REQ-027 MemAck outside REQ shall be ignored.

Reset
REQ-028 Rst_n low shall immediately force IDLE, MemReq=0, MemWe=0, MemByteEn=0, MemAddr=0, MemWData=0, StallOut=0, LoadDataOut=0, LoadValidOut=0, MisalignOut=0, BusErrOut=0, counter=0.
REQ-029 Reset during REQ shall abandon the transaction with no LoadValidOut pulse after release.

Verification
REQ-030 lw at 0x100, MemAck on the 2nd REQ cycle, MemRData=0xDEADBEEF -> LoadDataOut=0xDEADBEEF, LoadValidOut for 1 cycle, StallOut high 3 cycles.
REQ-031 Signed lb at 0x103, MemRData=0x80112233 -> MemByteEn=1000, LoadDataOut=0xFFFFFF80; repeated with LoadUnsignedIn=1 -> 0x00000080.
REQ-032 sh at 0x202, data 0x0000ABCD -> MemAddr=0x200, MemByteEn=1100, MemWData=0xABCDABCD, MemWe=1.
REQ-033 lw at 0x101 -> no MemReq, MisalignOut pulse, no LoadValidOut.
REQ-034 Load with no MemAck -> MemReq high for 16 cycles, then BusErrOut pulse and LoadDataOut=0.
REQ-035 Rst_n low in mid-REQ -> all outputs zero immediately; the next access proceeds normally.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// Data-memory access controller between EX/MEM and a single-port memory.
// Handles lane alignment, load extension, misalignment trapping and request timeout.
module mem_access_ctrl (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        MemReadIn,
  input  logic        MemWriteIn,
  input  logic [1:0]  bytes2LoadIn,
  input  logic [1:0]  bytes2StoreIn,
  input  logic        LoadUnsignedIn,
  input  logic [31:0] ALUResultIn,
  input  logic [31:0] MemWriteDataIn,
  output logic        MemReq,
  output logic        MemWe,
  output logic [31:0] MemAddr,
  output logic [3:0]  MemByteEn,
  output logic [31:0] MemWData,
  input  logic        MemAck,
  input  logic [31:0] MemRData,
  output logic        StallOut,
  output logic [31:0] LoadDataOut,
  output logic        LoadValidOut,
  output logic        MisalignOut,
  output logic        BusErrOut
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StReq  = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  logic [1:0]  stateQ, stateD;
  logic [3:0]  toCntQ;
  logic        weQ, unsQ;
  logic [1:0]  sizeQ, offQ;

  logic        access, isHalf, isByte, misaligned, timeout;
  logic [1:0]  size;
  logic [3:0]  beNew;
  logic [31:0] wdNew, laneWord, extData;

  // Request decode; a simultaneous read+write is treated as a store only.
  always_comb begin
    access     = MemReadIn | MemWriteIn;
    size       = MemWriteIn ? bytes2StoreIn : bytes2LoadIn;
    isHalf     = (size == 2'b01);
    isByte     = (size == 2'b10);
    misaligned = (isHalf & ALUResultIn[0]) |
                 (~isHalf & ~isByte & (ALUResultIn[1:0] != 2'b00));
    if (isByte) begin
      beNew = 4'b0001 << ALUResultIn[1:0];
      wdNew = {4{MemWriteDataIn[7:0]}};
    end else if (isHalf) begin
      beNew = ALUResultIn[1] ? 4'b1100 : 4'b0011;
      wdNew = {2{MemWriteDataIn[15:0]}};
    end else begin
      beNew = 4'b1111;
      wdNew = MemWriteDataIn;
    end
  end

  // Right-justify the addressed lane(s) and extend.
  always_comb begin
    laneWord = MemRData >> {offQ, 3'b000};
    if (sizeQ == 2'b10) begin
      extData = {{24{~unsQ & laneWord[7]}}, laneWord[7:0]};
    end else if (sizeQ == 2'b01) begin
      extData = {{16{~unsQ & laneWord[15]}}, laneWord[15:0]};
    end else begin
      extData = laneWord;
    end
  end

  assign timeout = ~MemAck & (toCntQ == 4'hF);

  always_comb begin
    stateD = stateQ;
    case (stateQ)
      StIdle:  if (access) stateD = misaligned ? StDone : StReq;
      StReq:   if (MemAck || timeout) stateD = StDone;
      StDone:  stateD = StIdle;
      default: stateD = StIdle;
    endcase
  end

  assign MemReq   = (stateQ == StReq);
  assign MemWe    = MemReq & weQ;
  assign StallOut = Rst_n & (((stateQ == StIdle) & access) | MemReq);

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      stateQ       <= StIdle;
      toCntQ       <= 4'd0;
      weQ          <= 1'b0;
      unsQ         <= 1'b0;
      sizeQ        <= 2'b00;
      offQ         <= 2'b00;
      MemAddr      <= 32'd0;
      MemByteEn    <= 4'd0;
      MemWData     <= 32'd0;
      LoadDataOut  <= 32'd0;
      LoadValidOut <= 1'b0;
      MisalignOut  <= 1'b0;
      BusErrOut    <= 1'b0;
    end else begin
      stateQ       <= stateD;
      LoadValidOut <= 1'b0;
      MisalignOut  <= 1'b0;
      BusErrOut    <= 1'b0;
      case (stateQ)
        StIdle: begin
          if (access) begin
            if (misaligned) begin
              MisalignOut <= 1'b1;
            end else begin
              weQ       <= MemWriteIn;
              unsQ      <= LoadUnsignedIn;
              sizeQ     <= size;
              offQ      <= ALUResultIn[1:0];
              MemAddr   <= {ALUResultIn[31:2], 2'b00};
              MemByteEn <= beNew;
              MemWData  <= wdNew;
              toCntQ    <= 4'd0;
            end
          end
        end
        StReq: begin
          if (MemAck) begin
            if (!weQ) begin
              LoadDataOut  <= extData;
              LoadValidOut <= 1'b1;
            end
          end else if (timeout) begin
            BusErrOut   <= 1'b1;
            LoadDataOut <= 32'd0;
          end else begin
            toCntQ <= toCntQ + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: fixed vectors, reset corner case and randomized
// accesses checked against a transaction-level model.
module tb_mem_access_ctrl;

  logic        Clk = 1'b0;
  logic        Rst_n = 1'b0;
  logic        MemReadIn = 1'b0, MemWriteIn = 1'b0, LoadUnsignedIn = 1'b0;
  logic [1:0]  bytes2LoadIn = 2'b00, bytes2StoreIn = 2'b00;
  logic [31:0] ALUResultIn = 32'd0, MemWriteDataIn = 32'd0, MemRData = 32'd0;
  logic        MemAck = 1'b0;
  logic        MemReq, MemWe, StallOut, LoadValidOut, MisalignOut, BusErrOut;
  logic [31:0] MemAddr, MemWData, LoadDataOut;
  logic [3:0]  MemByteEn;

  mem_access_ctrl dut (
    .Clk(Clk), .Rst_n(Rst_n), .MemReadIn(MemReadIn), .MemWriteIn(MemWriteIn),
    .bytes2LoadIn(bytes2LoadIn), .bytes2StoreIn(bytes2StoreIn),
    .LoadUnsignedIn(LoadUnsignedIn), .ALUResultIn(ALUResultIn),
    .MemWriteDataIn(MemWriteDataIn), .MemReq(MemReq), .MemWe(MemWe), .MemAddr(MemAddr),
    .MemByteEn(MemByteEn), .MemWData(MemWData), .MemAck(MemAck), .MemRData(MemRData),
    .StallOut(StallOut), .LoadDataOut(LoadDataOut), .LoadValidOut(LoadValidOut),
    .MisalignOut(MisalignOut), .BusErrOut(BusErrOut)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic        rd, wr;
    logic [1:0]  szL, szS;
    logic        uns;
    logic [31:0] addr, wdata, rdata;
    int          ack;   // REQ cycle carrying MemAck, 0 = never
    logic [3:0]  be;
    logic [31:0] wd, ld;
    logic        mis;
  } vec_t;

  int nCmp = 0, nFail = 0;
  logic [31:0] lastLoad = 32'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCmp++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic rd, input logic wr, input logic [1:0] szL,
                              input logic [1:0] szS, input logic uns, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [31:0] rdata,
                              input int ack, input logic [3:0] be, input logic [31:0] wd,
                              input logic [31:0] ld, input logic mis);
    vec_t v;
    v.rd = rd; v.wr = wr; v.szL = szL; v.szS = szS; v.uns = uns; v.addr = addr;
    v.wdata = wdata; v.rdata = rdata; v.ack = ack; v.be = be; v.wd = wd; v.ld = ld;
    v.mis = mis;
    return v;
  endfunction

  // Transaction-level model: access width in bytes drives every expectation.
  function automatic vec_t model(input vec_t vi);
    vec_t v;
    int n, off;
    logic [1:0] sz;
    logic [31:0] mask, val;
    v = vi;
    sz = v.wr ? v.szS : v.szL;
    n = (sz == 2'd1) ? 2 : (sz == 2'd2) ? 1 : 4;
    off = int'(v.addr[1:0]);
    v.mis = (off % n) != 0;
    v.be = 4'(((1 << n) - 1) << off);
    for (int j = 0; j < 4; j++) v.wd[8*j +: 8] = v.wdata[8*(j % n) +: 8];
    mask = (n == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * n)) - 32'd1);
    val = (v.rdata >> (8 * off)) & mask;
    if (!v.uns && n < 4 && val[8*n-1]) val = val | ~mask;
    v.ld = val;
    return v;
  endfunction

  task automatic doAccess(input vec_t v, input string tag);
    logic isLoad;
    int nReq;
    isLoad = v.rd & ~v.wr;
    @(posedge Clk); #1;
    MemReadIn = v.rd; MemWriteIn = v.wr; bytes2LoadIn = v.szL; bytes2StoreIn = v.szS;
    LoadUnsignedIn = v.uns; ALUResultIn = v.addr; MemWriteDataIn = v.wdata;
    MemAck = 1'($urandom_range(0, 1)); MemRData = $urandom;   // stray ack must be ignored
    @(negedge Clk);
    chk({tag, ".idle_stall"}, StallOut, 1);
    chk({tag, ".idle_req"}, MemReq, 0);
    @(posedge Clk); #1;
    MemReadIn = 1'b0; MemWriteIn = 1'b0; MemAck = 1'b0;
    if (!v.mis) begin
      nReq = (v.ack == 0) ? 16 : v.ack;
      for (int i = 1; i <= nReq; i++) begin
        if (i > 1) begin @(posedge Clk); #1; end
        MemAck = (i == v.ack);
        MemRData = (i == v.ack) ? v.rdata : $urandom;
        ALUResultIn = $urandom; MemWriteDataIn = $urandom; LoadUnsignedIn = ~v.uns;
        @(negedge Clk);
        chk({tag, ".req"}, MemReq, 1);
        chk({tag, ".stall"}, StallOut, 1);
        chk({tag, ".addr"}, MemAddr, {v.addr[31:2], 2'b00});
        chk({tag, ".be"}, MemByteEn, v.be);
        chk({tag, ".we"}, MemWe, v.wr);
        if (v.wr) chk({tag, ".wdata"}, MemWData, v.wd);
      end
      @(posedge Clk); #1;
      MemAck = 1'b0;
    end
    @(negedge Clk);
    if (!v.mis) begin
      if (v.ack == 0) lastLoad = 32'd0;
      else if (isLoad) lastLoad = v.ld;
    end
    chk({tag, ".done_req"}, MemReq, 0);
    chk({tag, ".done_we"}, MemWe, 0);
    chk({tag, ".done_stall"}, StallOut, 0);
    chk({tag, ".misalign"}, MisalignOut, v.mis);
    chk({tag, ".buserr"}, BusErrOut, !v.mis && v.ack == 0);
    chk({tag, ".lvalid"}, LoadValidOut, !v.mis && isLoad && v.ack != 0);
    chk({tag, ".ldata"}, LoadDataOut, lastLoad);
    @(negedge Clk);
    chk({tag, ".idle_lvalid"}, LoadValidOut, 0);
    chk({tag, ".idle_misalign"}, MisalignOut, 0);
    chk({tag, ".idle_reqoff"}, MemReq, 0);
  endtask

  task automatic chkAllZero(input string tag);
    chk({tag, ".req"}, MemReq, 0);
    chk({tag, ".we"}, MemWe, 0);
    chk({tag, ".be"}, MemByteEn, 0);
    chk({tag, ".addr"}, MemAddr, 0);
    chk({tag, ".wdata"}, MemWData, 0);
    chk({tag, ".stall"}, StallOut, 0);
    chk({tag, ".ldata"}, LoadDataOut, 0);
    chk({tag, ".lvalid"}, LoadValidOut, 0);
    chk({tag, ".misalign"}, MisalignOut, 0);
    chk({tag, ".buserr"}, BusErrOut, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[11];
    vec_t v;
    int op;
    tbl[0]  = mk(1, 0, 2'b00, 2'b00, 0, 32'h100, 32'h0, 32'hDEADBEEF, 2,
                 4'b1111, 32'h0, 32'hDEADBEEF, 0);
    tbl[1]  = mk(1, 0, 2'b10, 2'b00, 0, 32'h103, 32'h0, 32'h80112233, 1,
                 4'b1000, 32'h0, 32'hFFFFFF80, 0);
    tbl[2]  = mk(1, 0, 2'b10, 2'b00, 1, 32'h103, 32'h0, 32'h80112233, 3,
                 4'b1000, 32'h0, 32'h00000080, 0);
    tbl[3]  = mk(0, 1, 2'b00, 2'b01, 0, 32'h202, 32'h0000ABCD, 32'h0, 1,
                 4'b1100, 32'hABCDABCD, 32'h0, 0);
    tbl[4]  = mk(1, 0, 2'b00, 2'b00, 0, 32'h101, 32'h0, 32'h0, 1,
                 4'b0000, 32'h0, 32'h0, 1);
    tbl[5]  = mk(1, 0, 2'b00, 2'b00, 0, 32'h300, 32'h0, 32'h0, 0,
                 4'b1111, 32'h0, 32'h0, 0);
    tbl[6]  = mk(1, 1, 2'b00, 2'b10, 0, 32'h5, 32'h00000012, 32'h0, 2,
                 4'b0010, 32'h12121212, 32'h0, 0);
    tbl[7]  = mk(1, 0, 2'b01, 2'b00, 1, 32'h2, 32'h0, 32'h80017FFF, 1,
                 4'b1100, 32'h0, 32'h00008001, 0);
    tbl[8]  = mk(1, 0, 2'b11, 2'b00, 0, 32'h8, 32'h0, 32'h12345678, 4,
                 4'b1111, 32'h0, 32'h12345678, 0);
    tbl[9]  = mk(0, 1, 2'b00, 2'b01, 0, 32'h201, 32'h1234, 32'h0, 1,
                 4'b0000, 32'h0, 32'h0, 1);
    tbl[10] = mk(1, 0, 2'b01, 2'b00, 0, 32'h10, 32'h0, 32'h0000F00D, 16,
                 4'b0011, 32'h0, 32'hFFFFF00D, 0);

    MemReadIn = 1'b1;
    #2;
    chkAllZero("reset");
    #20;
    @(negedge Clk);
    MemReadIn = 1'b0;
    Rst_n = 1'b1;

    for (int k = 0; k < 11; k++) doAccess(tbl[k], $sformatf("vec%0d", k));

    // Reset in mid-REQ abandons the load.
    doAccess(tbl[2], "preload");
    @(posedge Clk); #1;
    MemReadIn = 1'b1; bytes2LoadIn = 2'b00; ALUResultIn = 32'h400; MemAck = 1'b0;
    @(posedge Clk); #1;
    @(posedge Clk); #1;
    Rst_n = 1'b0;
    #1;
    chkAllZero("midreset");
    @(negedge Clk);
    MemReadIn = 1'b0;
    Rst_n = 1'b1;
    lastLoad = 32'd0;
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk);
      chk("postreset.lvalid", LoadValidOut, 0);
      chk("postreset.req", MemReq, 0);
    end
    doAccess(tbl[0], "afterreset");

    for (int r = 0; r < 150; r++) begin
      op = $urandom_range(0, 2);
      v.rd = (op != 1); v.wr = (op != 0);
      v.szL = 2'($urandom_range(0, 3)); v.szS = 2'($urandom_range(0, 3));
      v.uns = 1'($urandom_range(0, 1));
      v.addr = $urandom; v.wdata = $urandom; v.rdata = $urandom;
      v.ack = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 16);
      doAccess(model(v), $sformatf("rnd%0d", r));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
    $finish;
  end

endmodule
